// File: rtl/ring_ptr_ctrl_pkg.sv
// ring_pkg: shared width helpers and level-update opcode for ring_ptr_ctrl.
package ring_pkg;

    // Width of a storage index for a buffer of the given depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of an occupancy count that must hold 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } lvl_op_e;

endpackage

// File: rtl/ring_ptr_ctrl_step.sv
// ring_step: combinational modulo-DEPTH pointer incrementer.
// wrap flags the step from DEPTH-1 back to 0.
module ring_step
    import ring_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [PW-1:0] ptr_next,
    output logic          wrap
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Advance by one when enabled, folding the last index back to zero.
    always_comb begin
        wrap     = en && (ptr == LAST);
        ptr_next = ptr;
        if (en) begin
            ptr_next = (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ring_ptr_ctrl.sv
// ring_ptr_ctrl: read/write ring pointers plus occupancy level for a
// circular buffer of any depth >= 2 (non-power-of-two allowed).
// Optional sticky overflow/underflow flags: define RING_PTR_CTRL_ERR_EN.
// Note: rst_n is an active-high asynchronous reset despite its name.
module ring_ptr_ctrl
    import ring_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ALMOST_FULL  = DEPTH - 1,
    parameter int ALMOST_EMPTY = 1,
    localparam int PW = ptr_w(DEPTH),
    localparam int LW = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty
`ifdef RING_PTR_CTRL_ERR_EN
    ,
    output logic          ovf_err,
    output logic          unf_err
`endif
);

    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          wr_wrap;
    logic          rd_wrap;
    lvl_op_e       lvl_op;

    // Flags come straight off the registered level so they move only on an edge.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(ALMOST_FULL));
    assign almost_empty = (level <= LW'(ALMOST_EMPTY));

    // A read on empty is refused even if a write lands the same cycle (no bypass);
    // a write on full is fine as long as a read frees the slot in the same cycle.
    assign rd_ok = rd_en && !empty && !flush;
    assign wr_ok = wr_en && !flush && (!full || rd_ok);

    ring_step #(.DEPTH(DEPTH)) u_wr_step (
        .ptr      (wr_ptr),
        .en       (wr_ok),
        .ptr_next (wr_ptr_nxt),
        .wrap     (wr_wrap)
    );

    ring_step #(.DEPTH(DEPTH)) u_rd_step (
        .ptr      (rd_ptr),
        .en       (rd_ok),
        .ptr_next (rd_ptr_nxt),
        .wrap     (rd_wrap)
    );

    // Decode the level change; simultaneous accept leaves occupancy unchanged.
    always_comb begin
        lvl_op = LVL_HOLD;
        if (wr_ok && !rd_ok) begin
            lvl_op = LVL_INC;
        end else if (rd_ok && !wr_ok) begin
            lvl_op = LVL_DEC;
        end
    end

    // Pointer registers; flush returns both to the origin.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_wrap ? '0 : wr_ptr_nxt;
            rd_ptr <= rd_wrap ? '0 : rd_ptr_nxt;
        end
    end

    // Occupancy register; accept gating keeps it within 0..DEPTH.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case (lvl_op)
                LVL_INC:  level <= level + 1'b1;
                LVL_DEC:  level <= level - 1'b1;
                LVL_HOLD: level <= level;
                default:  level <= level;
            endcase
        end
    end

`ifdef RING_PTR_CTRL_ERR_EN
    // Sticky records of refused requests, cleared only by reset or flush.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (flush) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (wr_en && !wr_ok) ovf_err <= 1'b1;
            if (rd_en && !rd_ok) unf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_ptr_ctrl.sv
// Bench for ring_ptr_ctrl at DEPTH=5: directed vectors with literal
// expectations plus a per-cycle compare against a count-based model.
module tb_ring_ptr_ctrl;

    localparam int DEPTH = 5;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_ok, rd_ok;
    logic [2:0] wr_ptr, rd_ptr;
    logic [2:0] level;
    logic       full, empty, almost_full, almost_empty;
`ifdef RING_PTR_CTRL_ERR_EN
    logic       ovf_err, unf_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic cap_wr, cap_rd;

    // Model: total accepted writes/reads since the last clear.
    int  m_wcnt = 0;
    int  m_rcnt = 0;
    bit  m_ovf = 0;
    bit  m_unf = 0;

    ring_ptr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef RING_PTR_CTRL_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .unf_err      (unf_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_level();
        return m_wcnt - m_rcnt;
    endfunction

    function automatic bit m_rd_acc();
        return rd_en && (m_level() > 0) && !flush;
    endfunction

    function automatic bit m_wr_acc();
        return wr_en && !flush && ((m_level() < DEPTH) || m_rd_acc());
    endfunction

    // Model state update.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_wcnt = 0; m_rcnt = 0; m_ovf = 0; m_unf = 0;
        end else if (flush) begin
            m_wcnt = 0; m_rcnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            bit w, r;
            w = m_wr_acc();
            r = m_rd_acc();
            if (wr_en && !w) m_ovf = 1;
            if (rd_en && !r) m_unf = 1;
            if (w) m_wcnt++;
            if (r) m_rcnt++;
        end
    end

    // Compare every cycle, midway between active edges.
    always @(negedge clk) begin
        int lv;
        lv = m_level();
        chk("cmp_wr_ok", wr_ok, m_wr_acc());
        chk("cmp_rd_ok", rd_ok, m_rd_acc());
        chk("cmp_wr_ptr", wr_ptr, m_wcnt % DEPTH);
        chk("cmp_rd_ptr", rd_ptr, m_rcnt % DEPTH);
        chk("cmp_level", level, lv);
        chk("cmp_full", full, lv == DEPTH);
        chk("cmp_empty", empty, lv == 0);
        chk("cmp_afull", almost_full, lv >= AF);
        chk("cmp_aempty", almost_empty, lv <= AE);
`ifdef RING_PTR_CTRL_ERR_EN
        chk("cmp_ovf", ovf_err, m_ovf);
        chk("cmp_unf", unf_err, m_unf);
`endif
    end

    // One cycle of stimulus, entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic w, input logic r, input logic f);
        wr_en = w; rd_en = r; flush = f;
        #2;
        cap_wr = wr_ok;
        cap_rd = rd_ok;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int exp_af [5] = '{0, 0, 0, 1, 1};
        int exp_ae [5] = '{1, 0, 0, 0, 0};

        #12 rst_n = 1'b0;
        @(posedge clk); #1;

        chk("rst_level", level, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);

        // Fill from empty.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 0, 0);
            chk("fill_wr_ok", cap_wr, 1);
            chk("fill_wr_ptr", wr_ptr, (i + 1) % DEPTH);
            chk("fill_level", level, i + 1);
            chk("fill_afull", almost_full, exp_af[i]);
            chk("fill_aempty", almost_empty, exp_ae[i]);
        end
        chk("fill_full", full, 1);

        // Write on full is refused with no state change.
        cyc(1, 0, 0);
        chk("ovf_wr_ok", cap_wr, 0);
        chk("ovf_wr_ptr", wr_ptr, 0);
        chk("ovf_level", level, 5);
`ifdef RING_PTR_CTRL_ERR_EN
        chk("ovf_err_set", ovf_err, 1);
`endif

        // Streaming through a full buffer.
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 0);
            chk("stream_wr_ok", cap_wr, 1);
            chk("stream_rd_ok", cap_rd, 1);
            chk("stream_level", level, 5);
        end
        chk("stream_rd_ptr", rd_ptr, 2);
        chk("stream_wr_ptr", wr_ptr, 2);

        cyc(0, 0, 1);
        chk("flush1_level", level, 0);
        chk("flush1_rd_ptr", rd_ptr, 0);

        // Read+write on empty: write only.
        cyc(1, 1, 0);
        chk("emp_rw_wr_ok", cap_wr, 1);
        chk("emp_rw_rd_ok", cap_rd, 0);
        chk("emp_rw_level", level, 1);
        chk("emp_rw_rd_ptr", rd_ptr, 0);

        // Build wr=4 rd=1 level=3.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("pre_fl_wr_ptr", wr_ptr, 4);
        chk("pre_fl_rd_ptr", rd_ptr, 1);
        chk("pre_fl_level", level, 3);

        // Flush beats a concurrent write.
        cyc(1, 0, 1);
        chk("flush_wr_ok", cap_wr, 0);
        chk("flush_wr_ptr", wr_ptr, 0);
        chk("flush_rd_ptr", rd_ptr, 0);
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);

        // Asynchronous reset between edges at level 2.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("prerst_level", level, 2);
        #1 rst_n = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_wr_ptr", wr_ptr, 0);
        chk("arst_empty", empty, 1);
        #1 rst_n = 1'b0;
        cyc(1, 0, 0);
        chk("postrst_level", level, 1);
        chk("postrst_wr_ptr", wr_ptr, 1);

        // Drain then read on empty.
        cyc(0, 1, 0);
        chk("drain_level", level, 0);
        chk("drain_rd_ptr", rd_ptr, 1);
        cyc(0, 1, 0);
        chk("unf_rd_ok", cap_rd, 0);
        chk("unf_rd_ptr", rd_ptr, 1);
        chk("unf_level", level, 0);
`ifdef RING_PTR_CTRL_ERR_EN
        chk("unf_err_set", unf_err, 1);
        cyc(0, 0, 0);
        chk("unf_err_hold", unf_err, 1);
        cyc(0, 0, 1);
        chk("unf_err_clr", unf_err, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0);
        chk("err_ovf_clear", ovf_err, 0);
        cyc(1, 0, 0);
        chk("err_ovf_set", ovf_err, 1);
`endif

        cyc(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
